button_counter: RTL and testbench



---
 rtl/button_counter_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 57 +++++
 rtl/button_counter.sv | 67 ++++++
 tb/tb_button_counter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_counter_pkg.sv
// Shared board-level defaults and count-arbitration helpers for the button counter.
package button_counter_pkg;

  localparam int unsigned BC_WIDTH           = 4;
  localparam int unsigned BC_DEBOUNCE_CYCLES = 4;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2
  } cnt_op_e;

  // Simultaneous UP and DOWN cancel out.
  function automatic cnt_op_e count_op(input logic up, input logic dn);
    cnt_op_e op;
    op = OP_HOLD;
    if (up && !dn) begin
      op = OP_INC;
    end else if (dn && !up) begin
      op = OP_DEC;
    end
    return op;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stable-count debouncer and rising-edge event for one raw button.
module btn_debounce
  import button_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = BC_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic evt
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             db_q;
  logic             db_d;
  logic             dly_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      dly_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      db_q  <= db_d;
      dly_q <= db_q;
      cnt_q <= cnt_d;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_MAX) begin
        db_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign level = db_q;
  assign evt   = db_q & ~dly_q;

endmodule

// File: rtl/button_counter.sv
// Up/down counter stepped by debounced button presses, mirrored bit-reversed onto the LEDs.
module button_counter
  import button_counter_pkg::*;
#(
  parameter int unsigned WIDTH           = BC_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = BC_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_dn,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] led,
  output logic             up_evt,
  output logic             dn_evt
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             up_level;
  logic             dn_level;
  logic             unused_levels;
  cnt_op_e          op;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_up),
    .level (up_level),
    .evt   (up_evt)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_dn),
    .level (dn_level),
    .evt   (dn_evt)
  );

  assign unused_levels = up_level ^ dn_level;
  assign op            = count_op(up_evt, dn_evt);

  always_comb begin
    count_d = count_q;
    case (op)
      OP_INC:  count_d = count_q + WIDTH'(1);
      OP_DEC:  count_d = count_q - WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_led
    assign led[WIDTH-1-i] = count_q[i];
  end

endmodule

// File: tb/tb_button_counter.sv
// Scenario and randomized checks of button_counter against a sliding-window press model.
module tb_button_counter;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DC    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             btn_up;
  logic             btn_dn;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] led;
  logic             up_evt;
  logic             dn_evt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_counter #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DC)) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_up (btn_up),
    .btn_dn (btn_dn),
    .count  (count),
    .led    (led),
    .up_evt (up_evt),
    .dn_evt (dn_evt)
  );

  // Reference: raw samples reach the synchronized stream two edges late; the level
  // flips once the last DC stream values all disagree with it; a press event is the
  // cycle right after the level rose.
  bit rq[2][$];
  bit sq[2][$];
  bit m_lvl[2];
  bit m_prev[2];
  int m_count;

  always @(posedge clk) begin
    bit raw[2];
    bit e_up, e_dn, s, flip;
    raw[0] = btn_up;
    raw[1] = btn_dn;
    if (rst) begin
      m_count = 0;
      for (int b = 0; b < 2; b++) begin
        rq[b].delete();
        sq[b].delete();
        m_lvl[b]  = 1'b0;
        m_prev[b] = 1'b0;
      end
    end else begin
      e_up = m_lvl[0] && !m_prev[0];
      e_dn = m_lvl[1] && !m_prev[1];
      if (e_up && !e_dn) m_count = (m_count + 1) % 16;
      else if (e_dn && !e_up) m_count = (m_count + 15) % 16;
      for (int b = 0; b < 2; b++) begin
        m_prev[b] = m_lvl[b];
        s = (rq[b].size() >= 2) ? rq[b][rq[b].size()-2] : 1'b0;
        sq[b].push_back(s);
        while (sq[b].size() > DC) void'(sq[b].pop_front());
        flip = (sq[b].size() == DC);
        for (int i = 0; i < DC; i++) begin
          if (flip) begin
            if (sq[b][i] == m_lvl[b]) flip = 1'b0;
          end
        end
        if (flip) m_lvl[b] = ~m_lvl[b];
        rq[b].push_back(raw[b]);
        while (rq[b].size() > 4) void'(rq[b].pop_front());
      end
    end
  end

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    repeat (DC + 6) step();
  endtask

  task automatic press(input bit dn);
    @(negedge clk);
    if (dn) btn_dn = 1'b1; else btn_up = 1'b1;
    repeat (DC + 4) step();
    @(negedge clk);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    repeat (DC + 4) step();
  endtask

  task automatic set_count(input int v);
    do_reset();
    repeat (v) press(1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    checks++;
    if (count !== 4'd0 || led !== 4'd0 || up_evt !== 1'b0 || dn_evt !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%h led=%h up=%b dn=%b, want all 0", count, led, up_evt, dn_evt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_held_up();
    int bad;
    do_reset();
    @(negedge clk);
    btn_up = 1'b1;
    for (int n = 0; n <= 10; n++) begin
      step();
      checks++;
      if (up_evt !== (n == 5) || count !== ((n >= 6) ? 4'd1 : 4'd0)) begin
        errors++;
        $display("FAIL held_edge%0d: up_evt=%b count=%h, want %b %h", n, up_evt, count,
                 (n == 5), (n >= 6) ? 4'd1 : 4'd0);
      end
    end
    checks++;
    if (led !== 4'b1000) begin
      errors++;
      $display("FAIL held_led: got %b want 1000", led);
    end
    bad = 0;
    repeat (100) begin
      step();
      if (up_evt !== 1'b0 || count !== 4'd1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL held_repeat: %0d bad cycles, want 0", bad);
    end
    settle();
    checks++;
    if (count !== 4'd1) begin
      errors++;
      $display("FAIL release_no_evt: count=%h want 1", count);
    end
  endtask

  task automatic test_bounce();
    int evts;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      btn_up = ((i % 2) == 0);
      step();
    end
    @(negedge clk);
    btn_up = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      checks++;
      if (up_evt !== (i == 6) || count !== ((i == 7) ? 4'd1 : 4'd0)) begin
        errors++;
        $display("FAIL bounce_edge%0d: up_evt=%b count=%h", i, up_evt, count);
      end
    end
    settle();
    @(negedge clk);
    btn_up = 1'b1;
    repeat (3) step();
    @(negedge clk);
    btn_up = 1'b0;
    evts = 0;
    repeat (12) begin
      step();
      if (up_evt) evts++;
    end
    checks++;
    if (evts != 0 || count !== 4'd1) begin
      errors++;
      $display("FAIL glitch: evts=%0d count=%h, want 0 and 1", evts, count);
    end
  endtask

  task automatic test_wrap();
    set_count(15);
    checks++;
    if (count !== 4'd15 || led !== 4'hF) begin
      errors++;
      $display("FAIL wrap_15: count=%h led=%h want F F", count, led);
    end
    press(1'b0);
    checks++;
    if (count !== 4'd0 || led !== 4'd0) begin
      errors++;
      $display("FAIL wrap_up: count=%h led=%h want 0 0", count, led);
    end
    press(1'b1);
    checks++;
    if (count !== 4'd15) begin
      errors++;
      $display("FAIL wrap_dn: count=%h want F", count);
    end
  endtask

  task automatic test_simultaneous();
    int up_n, dn_n, both_n, bad;
    set_count(7);
    @(negedge clk);
    btn_up = 1'b1;
    btn_dn = 1'b1;
    up_n = 0; dn_n = 0; both_n = 0; bad = 0;
    repeat (12) begin
      step();
      if (up_evt) up_n++;
      if (dn_evt) dn_n++;
      if (up_evt && dn_evt) both_n++;
      if (count !== 4'd7) bad++;
    end
    checks++;
    if (up_n != 1 || dn_n != 1 || both_n != 1) begin
      errors++;
      $display("FAIL simul_evt: up=%0d dn=%0d both=%0d want 1 1 1", up_n, dn_n, both_n);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL simul_hold: %0d cycles count!=7", bad);
    end
    settle();
  endtask

  task automatic test_staggered();
    int up_n, dn_n, up_i, dn_i;
    bit saw8;
    set_count(7);
    @(negedge clk);
    btn_up = 1'b1;
    up_n = 0; dn_n = 0; up_i = -1; dn_i = -1; saw8 = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (up_evt) begin up_n++; up_i = i; end
      if (dn_evt) begin dn_n++; dn_i = i; end
      if (count == 4'd8) saw8 = 1;
      if (i == 1) begin
        @(negedge clk);
        btn_dn = 1'b1;
      end
    end
    checks++;
    if (up_n != 1 || dn_n != 1 || dn_i - up_i != 2) begin
      errors++;
      $display("FAIL stagger_evt: up=%0d@%0d dn=%0d@%0d", up_n, up_i, dn_n, dn_i);
    end
    checks++;
    if (!saw8 || count !== 4'd7) begin
      errors++;
      $display("FAIL stagger_count: saw8=%b final=%h want 1 7", saw8, count);
    end
    settle();
  endtask

  task automatic test_reset_mid();
    set_count(9);
    @(negedge clk);
    btn_up = 1'b1;
    repeat (4) step();
    @(negedge clk);
    rst = 1'b1;
    step();
    checks++;
    if (count !== 4'd0 || led !== 4'd0 || up_evt !== 1'b0 || dn_evt !== 1'b0) begin
      errors++;
      $display("FAIL midreset: count=%h led=%h up=%b dn=%b want 0", count, led, up_evt, dn_evt);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      checks++;
      if (up_evt !== (i == 6) || count !== ((i >= 7) ? 4'd1 : 4'd0)) begin
        errors++;
        $display("FAIL midreset_edge%0d: up_evt=%b count=%h", i, up_evt, count);
      end
    end
    settle();
  endtask

  task automatic test_random();
    int hold_up, hold_dn, bad;
    logic [3:0] exp_c;
    do_reset();
    hold_up = 0; hold_dn = 0; bad = 0;
    repeat (1500) begin
      @(negedge clk);
      if (hold_up == 0) begin
        btn_up = 1'($urandom_range(0, 1));
        hold_up = int'($urandom_range(1, 12));
      end
      if (hold_dn == 0) begin
        btn_dn = 1'($urandom_range(0, 1));
        hold_dn = int'($urandom_range(1, 12));
      end
      hold_up--;
      hold_dn--;
      rst = ($urandom_range(0, 299) == 0);
      step();
      exp_c = 4'(m_count);
      checks++;
      if (count !== exp_c || led !== rev4(exp_c) ||
          up_evt !== (m_lvl[0] && !m_prev[0]) || dn_evt !== (m_lvl[1] && !m_prev[1])) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random: count=%h led=%h up=%b dn=%b, want %h %h %b %b", count, led,
                   up_evt, dn_evt, exp_c, rev4(exp_c), m_lvl[0] && !m_prev[0],
                   m_lvl[1] && !m_prev[1]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    test_reset();
    test_held_up();
    test_bounce();
    test_wrap();
    test_simultaneous();
    test_staggered();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
